cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_pkg.sv | 26 ++
 rtl/run_cycle_counter.sv | 33 +++
 rtl/cpu_run_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run controller.
//   run_state_e  : controller FSM states
//   stop_cause_e : encoding of the StopCause output
// Optional feature macro: RUN_CTRL_BREAKPOINT_EN (adds a PC breakpoint).
package cpu_run_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned PC_W_DEF  = 8;
    localparam int unsigned CAUSE_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_LIMIT = 3'd1,
        CAUSE_HALT  = 3'd2,
        CAUSE_USER  = 3'd3,
        CAUSE_BREAK = 3'd4
    } stop_cause_e;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable.
//   clk, rst_n  : clock, async active-low reset
//   clr         : synchronous clear (wins over en)
//   en          : count enable
//   count       : registered count value
//   count_inc_c : combinational saturated count+1 (for look-ahead compares)
module run_cycle_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_inc_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Hold at all-ones instead of wrapping.
    assign count_inc_c = (count == CNT_MAX) ? count : count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_inc_c;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: gates the CPU clock enable for free runs, limited runs
// and single steps, and records why the last run stopped.
//   Clock, Reset_n     : clock, async active-low reset
//   Start, Step, Stop  : run request, single-step request, user abort
//   CycleLimit         : enabled cycles to run (0 = unlimited)
//   Halt, PC           : CPU halt indication and program counter
//   BreakAddr/Valid    : breakpoint (only with RUN_CTRL_BREAKPOINT_EN)
//   CpuEn, Running     : CPU clock enable, high in RUN or STEP
//   Done               : high in DONE
//   CycleCount         : enabled cycles since the last Start/Step
//   StopCause          : reason for the last stop (stop_cause_e)
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PC_W  = PC_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Step,
    input  logic               Stop,
    input  logic [CNT_W-1:0]   CycleLimit,
    input  logic               Halt,
    input  logic [PC_W-1:0]    PC,
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]    BreakAddr,
    input  logic               BreakValid,
`endif
    output logic               CpuEn,
    output logic               Running,
    output logic               Done,
    output logic [CNT_W-1:0]   CycleCount,
    output logic [CAUSE_W-1:0] StopCause
);

    run_state_e  state_q, state_d;
    stop_cause_e cause_q, cause_d;
    logic        cpu_en_q, running_q, done_q;
    logic        cnt_clr_c;
    logic        brk_hit_c;
    logic        limit_hit_c;
    logic [CNT_W-1:0] cnt_q, cnt_inc_c;

`ifdef RUN_CTRL_BREAKPOINT_EN
    assign brk_hit_c = BreakValid && (PC == BreakAddr);
`else
    logic unused_pc_c;
    assign unused_pc_c = ^PC;
    assign brk_hit_c   = 1'b0;
`endif

    // Look ahead one count: the current RUN cycle is already an enabled cycle.
    assign limit_hit_c = (CycleLimit != '0) && (cnt_inc_c >= CycleLimit);

    run_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk         (Clock),
        .rst_n       (Reset_n),
        .clr         (cnt_clr_c),
        .en          (cpu_en_q),
        .count       (cnt_q),
        .count_inc_c (cnt_inc_c)
    );

    // Next-state and stop-cause decode.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_clr_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    cnt_clr_c = 1'b1;
                end else if (Step) begin
                    state_d   = ST_STEP;
                    cause_d   = CAUSE_NONE;
                    cnt_clr_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_USER;
                end else if (Halt) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (brk_hit_c) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_BREAK;
                end else if (limit_hit_c) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_LIMIT;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs decoded from the next state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cpu_en_q  <= (state_d == ST_RUN) || (state_d == ST_STEP);
            running_q <= (state_d == ST_RUN) || (state_d == ST_STEP);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign CpuEn      = cpu_en_q;
    assign Running    = running_q;
    assign Done       = done_q;
    assign CycleCount = cnt_q;
    assign StopCause  = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl.
// A second instance with CNT_W=3 exercises counter saturation.
// Optional feature macro: RUN_CTRL_BREAKPOINT_EN.
module tb_cpu_run_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic        Start, Step, Stop, Halt;
    logic [15:0] CycleLimit;
    logic [7:0]  PC;
    logic        CpuEn, Running, Done;
    logic [15:0] CycleCount;
    logic [2:0]  StopCause;
`ifdef RUN_CTRL_BREAKPOINT_EN
    logic [7:0]  BreakAddr;
    logic        BreakValid;
`endif

    // Small-counter instance signals
    logic        s_start;
    logic        s_zero;
    logic [2:0]  s_limit;
    logic [7:0]  s_pc;
    logic        s_cpu_en, s_running, s_done;
    logic [2:0]  s_count;
    logic [2:0]  s_cause;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt;

    cpu_run_ctrl #(.CNT_W(16), .PC_W(8)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Step       (Step),
        .Stop       (Stop),
        .CycleLimit (CycleLimit),
        .Halt       (Halt),
        .PC         (PC),
`ifdef RUN_CTRL_BREAKPOINT_EN
        .BreakAddr  (BreakAddr),
        .BreakValid (BreakValid),
`endif
        .CpuEn      (CpuEn),
        .Running    (Running),
        .Done       (Done),
        .CycleCount (CycleCount),
        .StopCause  (StopCause)
    );

    cpu_run_ctrl #(.CNT_W(3), .PC_W(8)) dut_small (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (s_start),
        .Step       (s_zero),
        .Stop       (s_zero),
        .CycleLimit (s_limit),
        .Halt       (s_zero),
        .PC         (s_pc),
`ifdef RUN_CTRL_BREAKPOINT_EN
        .BreakAddr  (s_pc),
        .BreakValid (s_zero),
`endif
        .CpuEn      (s_cpu_en),
        .Running    (s_running),
        .Done       (s_done),
        .CycleCount (s_count),
        .StopCause  (s_cause)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        Start      = 1'b0;
        Step       = 1'b0;
        Stop       = 1'b0;
        Halt       = 1'b0;
        CycleLimit = 16'd0;
        PC         = 8'h00;
`ifdef RUN_CTRL_BREAKPOINT_EN
        BreakAddr  = 8'h10;
        BreakValid = 1'b0;
`endif
        s_start = 1'b0;
        s_zero  = 1'b0;
        s_limit = 3'd0;
        s_pc    = 8'h00;

        // Reset state
        #2;
        check("rst_cpuen",   32'(CpuEn),      32'd0);
        check("rst_running", 32'(Running),    32'd0);
        check("rst_done",    32'(Done),       32'd0);
        check("rst_count",   32'(CycleCount), 32'd0);
        check("rst_cause",   32'(StopCause),  32'd0);
        #10 Reset_n = 1'b1;

        // Limited run of 5 cycles; Start honoured on first edge after reset
        CycleLimit = 16'd5;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("lim_first_run", 32'(Running), 32'd1);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (CpuEn) en_cnt++;
            if (Done) break;
            tick();
        end
        check("lim_en_cycles", 32'(en_cnt),     32'd5);
        check("lim_done",      32'(Done),       32'd1);
        check("lim_count",     32'(CycleCount), 32'd5);
        check("lim_cause",     32'(StopCause),  32'd1);
        check("lim_cpuen_off", 32'(CpuEn),      32'd0);

        // Stop in DONE has no effect
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check("stop_done_done",  32'(Done),       32'd1);
        check("stop_done_cause", 32'(StopCause),  32'd1);
        check("stop_done_count", 32'(CycleCount), 32'd5);

        // Unlimited run, Halt on 3rd enabled cycle; Start ignored in RUN
        CycleLimit = 16'd0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("halt_clr_cause", 32'(StopCause), 32'd0);
        check("halt_clr_done",  32'(Done),      32'd0);
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("run_ignore_start", 32'(CycleCount), 32'd2);
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        check("halt_done",  32'(Done),       32'd1);
        check("halt_count", 32'(CycleCount), 32'd3);
        check("halt_cause", 32'(StopCause),  32'd2);

        // Stop and Halt together: user stop wins
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Stop = 1'b1;
        Halt = 1'b1;
        tick();
        Stop = 1'b0;
        Halt = 1'b0;
        check("user_done",  32'(Done),       32'd1);
        check("user_cause", 32'(StopCause),  32'd3);
        check("user_count", 32'(CycleCount), 32'd1);

        // Single step from DONE, then from IDLE
        Step = 1'b1;
        tick();
        Step = 1'b0;
        check("step_cpuen", 32'(CpuEn),     32'd1);
        check("step_cause", 32'(StopCause), 32'd0);
        tick();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        check("step2_cpuen", 32'(CpuEn), 32'd1);
        tick();
        check("step2_idle_cpuen", 32'(CpuEn),      32'd0);
        check("step2_running",    32'(Running),    32'd0);
        check("step2_done",       32'(Done),       32'd0);
        check("step2_count",      32'(CycleCount), 32'd1);

        // Start and Step together: RUN wins
        Start = 1'b1;
        Step  = 1'b1;
        tick();
        Start = 1'b0;
        Step  = 1'b0;
        tick();
        check("startstep_running", 32'(Running),    32'd1);
        check("startstep_count",   32'(CycleCount), 32'd1);

        // Limit lowered below count mid-run: stop next cycle
        tick();
        tick();
        check("lower_pre_count", 32'(CycleCount), 32'd3);
        CycleLimit = 16'd2;
        tick();
        check("lower_done",  32'(Done),       32'd1);
        check("lower_cause", 32'(StopCause),  32'd1);
        check("lower_count", 32'(CycleCount), 32'd4);

        // Async reset mid-run, between edges
        CycleLimit = 16'd0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        check("arst_cpuen",   32'(CpuEn),      32'd0);
        check("arst_running", 32'(Running),    32'd0);
        check("arst_done",    32'(Done),       32'd0);
        check("arst_count",   32'(CycleCount), 32'd0);
        check("arst_cause",   32'(StopCause),  32'd0);
        #2 Reset_n = 1'b1;
        CycleLimit = 16'd2;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("arst_start_running", 32'(Running), 32'd1);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (CpuEn) en_cnt++;
            if (Done) break;
            tick();
        end
        check("arst_en_cycles", 32'(en_cnt),     32'd2);
        check("arst_count2",    32'(CycleCount), 32'd2);
        check("arst_cause2",    32'(StopCause),  32'd1);

`ifdef RUN_CTRL_BREAKPOINT_EN
        // Breakpoint hit when PC reaches 8'h10 on the 7th enabled cycle
        CycleLimit = 16'd0;
        BreakAddr  = 8'h10;
        BreakValid = 1'b1;
        PC = 8'h00;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            PC = 8'(8'h09 + i);
            tick();
        end
        BreakValid = 1'b0;
        check("brk_done",  32'(Done),       32'd1);
        check("brk_cause", 32'(StopCause),  32'd4);
        check("brk_count", 32'(CycleCount), 32'd7);
`endif

        // Unlimited run on a 3-bit counter saturates at 7
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sat_count",   32'(s_count),   32'd7);
        check("sat_running", 32'(s_running), 32'd1);
        check("sat_done",    32'(s_done),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
